// File: rtl/div16_seq.sv
// Iterative restoring divider: one trial subtraction per clock under a start/busy/done
// handshake, producing unsigned quotient and remainder with a divide-by-zero flag.
module div16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [WIDTH:0] ONE_W1   = (WIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // R never exceeds the divisor between iterations, so its top bit is only
  // needed in the shifted value and the trial difference.
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] trial;

  assign r_sh  = {r_q, q_q[WIDTH-1]};
  assign trial = r_sh + ~{1'b0, d_q} + ONE_W1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (divisor == '0) ? FIN : RUN;
      RUN:  if (cnt_q == CNT_ONE) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    q_d    = q_q;
    r_d    = r_q;
    d_d    = d_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = CNT_INIT;
          dz_d  = (divisor == '0);
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (!trial[WIDTH]) begin
          r_d = trial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = r_sh[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
      end
      FIN: begin
        done_d = 1'b1;
        if (dz_q) begin
          // No iterations ran, so Q still holds the captured dividend.
          quo_d = '1;
          rem_d = q_q;
          dbz_d = 1'b1;
        end else begin
          quo_d = q_q;
          rem_d = r_q;
          dbz_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div16_seq.sv
// Directed and randomized checks of div16_seq against plain-arithmetic division.
module tb_div16_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_assert = 0;
  int n_fail   = 0;

  div16_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("done_after_accept", 32'(done), 32'd0);
  endtask

  // Waits for done and compares against the reference quotient/remainder.
  task automatic wait_result(input int elapsed, input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat;
    if (b == '0) begin
      eq = '1; er = a; ez = 1'b1; lat = 1;
    end else begin
      eq = a / b; er = a % b; ez = 1'b0; lat = W + 1;
    end
    k = elapsed;
    while (k < 60) begin
      @(posedge clk); @(negedge clk);
      k++;
      if (done) break;
      check("busy_during_op", 32'(busy), 32'd1);
    end
    check("latency", 32'(k), 32'(lat));
    check("busy_at_done", 32'(busy), 32'd0);
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(ez));
    $display("div %0d / %0d -> q=%0d r=%0d dz=%0d after %0d cycles",
             a, b, quotient, remainder, div_by_zero, k);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 16'h0001;
      2: return 16'h8000;
      3: return 16'hFFFF;
      4: return 16'($urandom_range(0, 15));
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 100 / 7
    start_op(16'd100, 16'd7);
    wait_result(0, 16'd100, 16'd7);
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);

    // back-to-back: second start in the done cycle; results held meanwhile
    start_op(16'hFFFF, 16'd1);
    wait_result(0, 16'hFFFF, 16'd1);
    start_op(16'd3, 16'd10);
    check("hold_quotient", 32'(quotient), 32'hFFFF);
    check("hold_remainder", 32'(remainder), 32'd0);
    wait_result(0, 16'd3, 16'd10);

    // divide by zero
    @(negedge clk);
    start_op(16'h1234, 16'd0);
    wait_result(0, 16'h1234, 16'd0);

    // start while busy is ignored
    @(negedge clk);
    start_op(16'd1000, 16'd33);
    repeat (7) begin @(posedge clk); @(negedge clk); end
    start = 1'b1; dividend = 16'd5; divisor = 16'd5;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    wait_result(8, 16'd1000, 16'd33);
    repeat (20) begin
      @(negedge clk);
      check("no_extra_done", 32'(done), 32'd0);
    end
    check("idle_busy", 32'(busy), 32'd0);

    // reset mid-division
    start_op(16'd500, 16'd9);
    repeat (5) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    repeat (20) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    start_op(16'd500, 16'd9);
    wait_result(0, 16'd500, 16'd9);

    // randomized sweep, back-to-back
    for (int i = 0; i < 2500; i++) begin
      ra = pick_operand();
      rb = pick_operand();
      start_op(ra, rb);
      wait_result(0, ra, rb);
      if (rb != '0) begin
        check("identity", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
        check("rem_lt_div", 32'(remainder < rb), 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
